nios2_system_v0_edge_pio_in: RTL and testbench
==============================================

# nios2_system_v0_edge_pio_in

Avalon-MM slave input port: samples an external WIDTH-bit level bus, synchronizes and debounces it, latches selected edges into a sticky capture register, and raises a maskable level interrupt to the Nios II. It is the read-side counterpart of the system's single-bit output PIO registers and sits on the same data-master interconnect with read latency 1.

## Interface
- WIDTH, 8: number of input bits, 1..32.
- EDGE_TYPE, 0: edge that sets capture bits: 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 16: consecutive cycles of a changed level required before it is accepted. 0 and 1 both mean no filtering.
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt, active-high.

## Operation
- Register map. Bits at or above WIDTH read as 0 and ignore writes.
  - addr 0, DATA (RO): the debounced level `stable`.
  - addr 1: reads 0; writes are ignored.
  - addr 2, IRQMASK (RW): per-bit interrupt enable.
  - addr 3, EDGECAP (R/W1C): sticky edge flags. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- A write is accepted in any cycle with chipselect=1 and write_n=0. There is no waitrequest.
- Synchronizer: a two-flop chain per bit, in_port -> sync1 -> sync2.
- Debounce, per bit, with a counter of width clog2(max(DEBOUNCE_CYCLES,2)):
  - sync2 == stable: the counter clears.
  - sync2 != stable and counter < N-1: the counter increments.
  - sync2 != stable and counter == N-1: stable <= sync2 and the counter clears. With N <= 1 this happens on the first differing cycle.
  - A pulse shorter than N cycles at sync2 never reaches `stable`.
- Edge detect: evaluated on the cycle `stable` changes; the capture bit sets on the same edge that `stable` updates.
  - rising = stable 0->1
  - falling = stable 1->0
  - any = either
- Simultaneous W1C and new edge on the same bit in the same cycle: the set wins and the bit stays 1.
- irq = OR over (EDGECAP & IRQMASK). It is combinational from the registers, with no extra delay.
- readdata <= mux(address) on every clock, regardless of chipselect.
- Reset clears sync1, sync2, stable, the counters, IRQMASK, EDGECAP and readdata; irq=0.
  - A line held high through reset is therefore seen as a 0->1 transition after release and captures a rising edge. This is intended, and is how software detects an asserted-at-boot input.
- Reset asserted mid-debounce or with pending captures discards everything; there is no partial state.

## Timing
- Read latency is 1. Address presented at edge k is reflected in readdata after edge k+1.
- Write to IRQMASK/EDGECAP at edge k takes effect in the register, and in irq, after edge k.
- Input latency: in_port settles before edge e1. Then sync2 updates at e2, and `stable` and EDGECAP update at e(2+max(N,1)); irq follows in the same cycle if masked in.
  - N=16: input change to irq takes 18 edges.
  - N<=1: 3 edges.
- A read of EDGECAP followed by a W1C leaves no lost-edge window: an edge landing on the clear cycle survives.

## Test plan
- Reset defaults: reset held 3 cycles with in_port=0 -> read each address; all reads return 0x00000000 and irq=0.
- Debounce acceptance (WIDTH=8, EDGE_TYPE=0, N=16):
  - Stimulus: IRQMASK=0x01, then in_port[0] 0->1 and held.
  - DATA bit 0 and EDGECAP=0x01 appear exactly 18 edges after the change; irq=1 from that cycle.
  - W1C of 0x01 drops irq on the next edge.
- Glitch rejection (N=16): in_port[3] pulses high for 15 cycles -> DATA, EDGECAP and irq stay 0. A 16-cycle pulse sets EDGECAP=0x08 on the rising edge only.
- Edge selection:
  - EDGE_TYPE=1: a 1->0 on bit 2 sets 0x04, and a 0->1 sets nothing.
  - EDGE_TYPE=2: both directions set 0x04.
  - With IRQMASK=0, EDGECAP still sets and irq stays 0.
- Collision: a W1C of 0x02 on the same edge that bit 1 sets again -> EDGECAP reads 0x02 afterwards and irq stays asserted.
- Mid-operation reset: a capture is pending and bit 5 is mid-debounce when reset pulses for 1 cycle. All registers read 0 and irq=0. If in_port[5] is still high, EDGECAP bit 5 sets 2+N edges after reset release.

Source files
------------

// File: rtl/nios2_system_v0_edge_pio_in_if.sv
// Avalon-MM slave bus bundle for the edge-capturing input PIO.
// The master drives address/strobes/write data and the slave returns registered read data.
interface nios2_system_v0_edge_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios2_system_v0_edge_pio_in.sv
// Input PIO: two-flop synchronizer, per-bit debounce, sticky W1C edge capture,
// and a maskable level interrupt. Avalon-MM slave with read latency 1.
module nios2_system_v0_edge_pio_in #(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    nios2_system_v0_edge_pio_in_if.slave  bus,
    input  logic [WIDTH-1:0]              in_port_i,
    output logic                          irq_o
);
    localparam int            NMAX  = (DEBOUNCE_CYCLES < 2) ? 2 : DEBOUNCE_CYCLES;
    localparam int            CW    = $clog2(NMAX);
    // With 0 or 1 cycles of filtering the limit is 0, so the first differing cycle is accepted.
    localparam logic [CW-1:0] LIMIT = (DEBOUNCE_CYCLES < 2) ? {CW{1'b0}} : CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r           = 32'h0000_0000;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [WIDTH-1:0] rise_s, fall_s, edge_s, wd_s;
    logic             wr_s;

    generate
        if (WIDTH < 32) begin : g_unused_wd
            logic unused_wd_s;
            assign unused_wd_s = ^bus.writedata[31:WIDTH];
        end
    endgenerate

    assign wr_s = bus.chipselect & ~bus.write_n;
    assign wd_s = bus.writedata[WIDTH-1:0];

    // Per-bit debounce: a changed level must persist for the full window before it is accepted.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = {CW{1'b0}};
            end else if (cnt_q[i] == LIMIT) begin
                cnt_d[i]    = {CW{1'b0}};
                stable_d[i] = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end
        end
    end

    // Edge selection on the accepted level, and register-file next state.
    always_comb begin
        rise_s = stable_d & ~stable_q;
        fall_s = ~stable_d & stable_q;
        case (EDGE_TYPE)
            0:       edge_s = rise_s;
            1:       edge_s = fall_s;
            default: edge_s = rise_s | fall_s;
        endcase

        if (wr_s && (bus.address == ADDR_IRQMASK)) begin
            mask_d = wd_s;
        end else begin
            mask_d = mask_q;
        end

        // A fresh edge wins over a simultaneous clear, so no edge is lost on the clear cycle.
        if (wr_s && (bus.address == ADDR_EDGECAP)) begin
            cap_d = (cap_q & ~wd_s) | edge_s;
        end else begin
            cap_d = cap_q | edge_s;
        end

        case (bus.address)
            ADDR_DATA:    rdata_d = zext(stable_q);
            ADDR_IRQMASK: rdata_d = zext(mask_q);
            ADDR_EDGECAP: rdata_d = zext(cap_q);
            default:      rdata_d = 32'h0000_0000;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q  <= {WIDTH{1'b0}};
            sync2_q  <= {WIDTH{1'b0}};
            stable_q <= {WIDTH{1'b0}};
            mask_q   <= {WIDTH{1'b0}};
            cap_q    <= {WIDTH{1'b0}};
            rdata_q  <= 32'h0000_0000;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            sync1_q  <= in_port_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.readdata = rdata_q;
    assign irq_o        = |(cap_q & mask_q);
endmodule

// File: tb/tb_nios2_system_v0_edge_pio_in.sv
// Bench for the edge-capturing input PIO: three variants (rising/N=16, falling/N=16,
// any/N=0) share one stimulus and are checked every cycle against a history-window model.
module tb_nios2_system_v0_edge_pio_in;
    localparam int ND = 3;
    localparam int HL = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        cs;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [ND-1:0] irq_w;
    logic [31:0] rd_w [ND];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  hist [HL];
    logic [7:0]  m_stable [ND];
    logic [7:0]  m_cap [ND];
    logic [7:0]  m_mask [ND];
    logic [31:0] m_rd [ND];
    int          neff  [ND] = '{16, 16, 1};
    int          etype [ND] = '{0, 1, 2};

    always #5 clk = ~clk;

    nios2_system_v0_edge_pio_in_if bus [ND] ();

    for (genvar g = 0; g < ND; g++) begin : g_bus
        assign bus[g].address    = address;
        assign bus[g].chipselect = cs;
        assign bus[g].write_n    = write_n;
        assign bus[g].writedata  = writedata;
        assign rd_w[g]           = bus[g].readdata;
    end

    nios2_system_v0_edge_pio_in #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut0 (
        .clk_i(clk), .reset_i(reset), .bus(bus[0]), .in_port_i(in_port), .irq_o(irq_w[0]));
    nios2_system_v0_edge_pio_in #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(16)) dut1 (
        .clk_i(clk), .reset_i(reset), .bus(bus[1]), .in_port_i(in_port), .irq_o(irq_w[1]));
    nios2_system_v0_edge_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0)) dut2 (
        .clk_i(clk), .reset_i(reset), .bus(bus[2]), .in_port_i(in_port), .irq_o(irq_w[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
        end
    endtask

    // Reference: a level is accepted once the synchronized input (two edges late)
    // has disagreed with the accepted level on each of the last N edges.
    task automatic model_edge();
        logic [7:0] ns, ev, w1c, rise, fall;
        logic       all_diff;
        for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = in_port;
        if (reset) begin
            for (int i = 0; i < HL; i++) hist[i] = 8'h00;
            for (int k = 0; k < ND; k++) begin
                m_stable[k] = 8'h00;
                m_cap[k]    = 8'h00;
                m_mask[k]   = 8'h00;
                m_rd[k]     = 32'h0;
            end
        end else begin
            for (int k = 0; k < ND; k++) begin
                case (address)
                    2'd0:    m_rd[k] = {24'h0, m_stable[k]};
                    2'd2:    m_rd[k] = {24'h0, m_mask[k]};
                    2'd3:    m_rd[k] = {24'h0, m_cap[k]};
                    default: m_rd[k] = 32'h0;
                endcase
                ns = m_stable[k];
                for (int b = 0; b < 8; b++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < neff[k]; j++) begin
                        if (hist[2+j][b] == m_stable[k][b]) all_diff = 1'b0;
                    end
                    if (all_diff) ns[b] = ~m_stable[k][b];
                end
                rise = ns & ~m_stable[k];
                fall = ~ns & m_stable[k];
                ev   = (etype[k] == 0) ? rise : (etype[k] == 1) ? fall : (rise | fall);
                w1c  = (cs && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
                m_cap[k] = (m_cap[k] & ~w1c) | ev;
                if (cs && !write_n && address == 2'd2) m_mask[k] = writedata[7:0];
                m_stable[k] = ns;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < ND; k++) begin
            check_eq($sformatf("readdata%0d", k), rd_w[k], m_rd[k]);
            check_eq($sformatf("irq%0d", k), {31'h0, irq_w[k]}, {31'h0, |(m_cap[k] & m_mask[k])});
        end
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        cs      = 1'b1;
        write_n = 1'b1;
        step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        cs        = 1'b1;
        write_n   = 1'b0;
        writedata = d;
        step();
        cs      = 1'b0;
        write_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < HL; i++) hist[i] = 8'h00;
        for (int k = 0; k < ND; k++) begin
            m_stable[k] = 8'h00;
            m_cap[k]    = 8'h00;
            m_mask[k]   = 8'h00;
            m_rd[k]     = 32'h0;
        end
        reset = 1'b1; address = 2'd0; cs = 1'b0; write_n = 1'b1;
        writedata = 32'h0; in_port = 8'h00;
        #2;
        repeat (3) step();
        reset = 1'b0;

        // Reset defaults on every address.
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            check_eq($sformatf("rst_rd_a%0d", a), rd_w[0], 32'h0);
            check_eq("rst_irq", 32'(irq_w), 32'h0);
        end

        // Debounce acceptance: exactly 18 edges from input change to capture.
        bus_write(2'd2, 32'h0000_0001);
        address = 2'd3; cs = 1'b1; write_n = 1'b1; in_port = 8'h01;
        repeat (17) step();
        check_eq("deb_irq_e17", {31'h0, irq_w[0]}, 32'h0);
        step();
        check_eq("deb_irq_e18", {31'h0, irq_w[0]}, 32'h1);
        check_eq("deb_rd_e18", rd_w[0], 32'h0);
        step();
        check_eq("deb_rd_e19", rd_w[0], 32'h1);
        bus_write(2'd3, 32'h0000_0001);
        check_eq("w1c_irq", {31'h0, irq_w[0]}, 32'h0);

        // Glitch rejection: 15 cycles rejected, 16 accepted.
        in_port = 8'h09; repeat (15) step();
        in_port = 8'h01; repeat (20) step();
        bus_read(2'd3);
        check_eq("glitch15_cap", rd_w[0], 32'h0);
        bus_read(2'd0);
        check_eq("glitch15_data", rd_w[0], 32'h1);
        in_port = 8'h09; repeat (16) step();
        in_port = 8'h01; repeat (20) step();
        bus_read(2'd3);
        check_eq("pulse16_cap_rise", rd_w[0], 32'h8);
        check_eq("pulse16_cap_fall", rd_w[1], 32'h8);

        // Edge selection with interrupts masked off.
        bus_write(2'd3, 32'h0000_00ff);
        bus_write(2'd2, 32'h0000_0000);
        in_port = 8'h05; repeat (20) step();
        bus_read(2'd3);
        check_eq("sel_rise_fallcap", rd_w[1], 32'h0);
        check_eq("sel_rise_anycap", rd_w[2], 32'h4);
        check_eq("sel_rise_risecap", rd_w[0], 32'h4);
        in_port = 8'h01; repeat (20) step();
        bus_read(2'd3);
        check_eq("sel_fall_fallcap", rd_w[1], 32'h4);
        check_eq("sel_fall_anycap", rd_w[2], 32'h4);
        check_eq("sel_masked_irq", 32'(irq_w), 32'h0);

        // Collision: clear and new set of bit 1 on the same edge.
        bus_write(2'd3, 32'h0000_00ff);
        bus_write(2'd2, 32'h0000_0002);
        in_port = 8'h03; repeat (25) step();
        in_port = 8'h01; repeat (25) step();
        bus_write(2'd3, 32'h0000_00ff);
        address = 2'd3; cs = 1'b1; write_n = 1'b1; in_port = 8'h03;
        repeat (17) step();
        write_n = 1'b0; writedata = 32'h0000_0002;
        step();
        write_n = 1'b1;
        check_eq("collide_irq", {31'h0, irq_w[0]}, 32'h1);
        bus_read(2'd3);
        check_eq("collide_cap", rd_w[0], 32'h2);

        // Mid-operation reset with a pending capture and bit 5 mid-debounce.
        in_port = 8'h23; repeat (8) step();
        reset = 1'b1; step(); reset = 1'b0;
        bus_read(2'd0);
        check_eq("mrst_data", rd_w[0], 32'h0);
        check_eq("mrst_irq", 32'(irq_w), 32'h0);
        bus_read(2'd2);
        check_eq("mrst_mask", rd_w[0], 32'h0);
        bus_read(2'd3);
        check_eq("mrst_cap", rd_w[0], 32'h0);
        repeat (15) step();
        check_eq("mrst_cap_e18", rd_w[0], 32'h0);
        step();
        check_eq("mrst_cap_e19", rd_w[0], 32'h23);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 24) == 0) in_port = in_port ^ 8'(1 << $urandom_range(0, 7));
            reset     = ($urandom_range(0, 499) == 0);
            cs        = 1'($urandom_range(0, 1));
            write_n   = ($urandom_range(0, 3) != 0);
            address   = 2'($urandom_range(0, 3));
            writedata = $urandom;
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
